// File: rtl/regfile_write_arbiter_if.sv
// Write-port arbitration bus: WB request, MC issue/result path, register-bank
// write port and hazard/status outputs.
interface regfile_write_arbiter_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             mc_issue;
  logic [4:0]       mc_issue_addr;
  logic             mc_valid;
  logic [4:0]       mc_addr;
  logic [31:0]      mc_data;
  logic             mc_ready;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_data;
  logic [31:0]      pend_mask;
  logic [CNT_W-1:0] fifo_count;
  logic             wb_stall;
  logic             waw_err;
  logic             issue_err;

  modport master (
    output wb_we, wb_addr, wb_data, mc_issue, mc_issue_addr,
           mc_valid, mc_addr, mc_data,
    input  mc_ready, rf_we, rf_addr, rf_data, pend_mask, fifo_count,
           wb_stall, waw_err, issue_err
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mc_issue, mc_issue_addr,
           mc_valid, mc_addr, mc_data,
    output mc_ready, rf_we, rf_addr, rf_data, pend_mask, fifo_count,
           wb_stall, waw_err, issue_err
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank write port between WB (fixed priority) and a
// buffered multi-cycle result path, with pending-write scoreboard and starvation stall.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter bit          ZERO_GUARD   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } mc_entry_t;

  mc_entry_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pend_q, pend_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic             wb_stall_q, wb_stall_d;
  logic             waw_err_q, waw_err_d;
  logic             issue_err_q, issue_err_d;

  logic             full_c, empty_c, push_c, pop_c, sel_c;
  mc_entry_t        head_c, sel_entry_c;

  // Arbitration, FIFO bookkeeping, scoreboard and starvation next-state
  always_comb begin
    full_c      = (count_q == CNT_W'(DEPTH));
    empty_c     = (count_q == '0);
    push_c      = bus.mc_valid && !full_c;
    pop_c       = !bus.wb_we && !empty_c;
    head_c      = fifo_q[rd_ptr_q];
    sel_c       = bus.wb_we || pop_c;
    sel_entry_c = bus.wb_we ? mc_entry_t'{addr: bus.wb_addr, data: bus.wb_data} : head_c;

    rf_we_d     = sel_c && !(ZERO_GUARD && (sel_entry_c.addr == 5'd0));
    rf_addr_d   = sel_c ? sel_entry_c.addr : rf_addr_q;
    rf_data_d   = sel_c ? sel_entry_c.data : rf_data_q;

    rd_ptr_d    = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d    = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // Clear before set so a same-cycle issue keeps the bit pending
    pend_d      = pend_q;
    if (pop_c)        pend_d[head_c.addr]        = 1'b0;
    if (bus.mc_issue) pend_d[bus.mc_issue_addr] = 1'b1;

    waw_err_d   = bus.wb_we && pend_q[bus.wb_addr];
    issue_err_d = bus.mc_issue && pend_q[bus.mc_issue_addr];

    starve_d    = '0;
    wb_stall_d  = 1'b0;
    if (bus.wb_we && !empty_c) begin
      if (starve_q == STV_W'(STARVE_LIMIT - 1)) wb_stall_d = 1'b1;
      else                                      starve_d   = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      starve_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      wb_stall_q  <= 1'b0;
      waw_err_q   <= 1'b0;
      issue_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      wb_stall_q  <= wb_stall_d;
      waw_err_q   <= waw_err_d;
      issue_err_q <= issue_err_d;
    end
  end

  // Payload storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push_c && !rst) fifo_q[wr_ptr_q] <= mc_entry_t'{addr: bus.mc_addr, data: bus.mc_data};
  end

  assign bus.mc_ready   = !full_c;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_data    = rf_data_q;
  assign bus.pend_mask  = pend_q;
  assign bus.fifo_count = count_q;
  assign bus.wb_stall   = wb_stall_q;
  assign bus.waw_err    = waw_err_q;
  assign bus.issue_err  = issue_err_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based reference model predicts
// each cycle's outputs and the ordered stream of register-bank writes.
module tb_regfile_write_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_data;
    logic [31:0]   pend;
    logic [CW-1:0] cnt;
    logic          ready;
    logic          stall;
    logic          waw;
    logic          iss;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ZERO_GUARD(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, passed = 0, cycle = 0, stalls_seen = 0, full_seen = 0;

  // Reference model state
  wr_t         m_fifo[$];
  logic [31:0] m_pend   = '0;
  int          m_starve = 0;
  logic        m_rf_we = 1'b0, m_stall = 1'b0, m_waw = 1'b0, m_iss = 1'b0;
  logic [4:0]  m_rf_addr = '0;
  logic [31:0] m_rf_data = '0;
  bit          mc_hold   = 1'b0;

  st_t exp_st[$];
  wr_t exp_wr[$];
  st_t e_s, a_s;
  wr_t e_w;
  logic [4:0] pick [6] = '{5'd0, 5'd3, 5'd4, 5'd7, 5'd9, 5'd31};

  // One clock edge of the reference model, from the inputs currently on the bus
  task automatic mdl_edge(output bit acc);
    int  sz;
    bit  pop, sel;
    wr_t h, s;
    acc = 1'b0;
    if (rst) begin
      m_fifo.delete();
      m_pend = '0; m_starve = 0;
      m_rf_we = 1'b0; m_rf_addr = '0; m_rf_data = '0;
      m_stall = 1'b0; m_waw = 1'b0; m_iss = 1'b0;
      return;
    end
    sz    = m_fifo.size();
    pop   = !bus.wb_we && (sz > 0);
    m_waw = bus.wb_we && m_pend[bus.wb_addr];
    m_iss = bus.mc_issue && m_pend[bus.mc_issue_addr];
    sel   = 1'b1;
    if (bus.wb_we) s = '{addr: bus.wb_addr, data: bus.wb_data};
    else if (pop) begin
      h = m_fifo.pop_front();
      s = h;
      m_pend[h.addr] = 1'b0;
    end else begin
      sel = 1'b0;
      s   = '0;
    end
    if (bus.mc_issue) m_pend[bus.mc_issue_addr] = 1'b1;
    m_rf_we = sel && (s.addr != 5'd0);
    if (sel) begin m_rf_addr = s.addr; m_rf_data = s.data; end
    if (m_rf_we) exp_wr.push_back(s);
    if (bus.mc_valid && (sz < DEPTH)) begin
      m_fifo.push_back('{addr: bus.mc_addr, data: bus.mc_data});
      acc = 1'b1;
    end
    if (bus.wb_we && (sz > 0)) begin
      m_starve++;
      m_stall = (m_starve == LIMIT);
      if (m_stall) m_starve = 0;
    end else begin
      m_starve = 0;
      m_stall  = 1'b0;
    end
  endtask

  function automatic st_t mdl_status();
    st_t s;
    s.rf_we   = m_rf_we;
    s.rf_addr = m_rf_addr;
    s.rf_data = m_rf_data;
    s.pend    = m_pend;
    s.cnt     = CW'(m_fifo.size());
    s.ready   = (m_fifo.size() < DEPTH);
    s.stall   = m_stall;
    s.waw     = m_waw;
    s.iss     = m_iss;
    return s;
  endfunction

  // Drive one cycle; a stalled pipeline drops wb_we, a refused MC result is held
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit iss, input logic [4:0] ia,
                     input bit mv, input logic [4:0] ma, input logic [31:0] md);
    bit acc;
    bus.wb_we         = we && !m_stall;
    bus.wb_addr       = wa;
    bus.wb_data       = wd;
    bus.mc_issue      = iss;
    bus.mc_issue_addr = ia;
    if (!mc_hold) begin
      bus.mc_valid = mv;
      bus.mc_addr  = ma;
      bus.mc_data  = md;
    end
    mdl_edge(acc);
    mc_hold = bus.mc_valid && !acc;
    @(posedge clk);
    exp_st.push_back(mdl_status());
    cycle++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: per-cycle status and in-order write stream
  always @(negedge clk) begin
    if (exp_st.size() > 0) begin
      e_s = exp_st.pop_front();
      a_s.rf_we   = bus.rf_we;
      a_s.rf_addr = bus.rf_addr;
      a_s.rf_data = bus.rf_data;
      a_s.pend    = bus.pend_mask;
      a_s.cnt     = bus.fifo_count;
      a_s.ready   = bus.mc_ready;
      a_s.stall   = bus.wb_stall;
      a_s.waw     = bus.waw_err;
      a_s.iss     = bus.issue_err;
      checks++;
      if (a_s === e_s) passed++;
      else $display("FAIL status cycle %0d: got %h want %h", cycle, a_s, e_s);
    end
    if (bus.rf_we === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        $display("FAIL write cycle %0d: unexpected r%0d=%h, none expected", cycle, bus.rf_addr, bus.rf_data);
      end else begin
        e_w = exp_wr.pop_front();
        if (bus.rf_addr === e_w.addr && bus.rf_data === e_w.data) passed++;
        else $display("FAIL write cycle %0d: got r%0d=%h want r%0d=%h",
                      cycle, bus.rf_addr, bus.rf_data, e_w.addr, e_w.data);
      end
    end
    if (bus.wb_stall === 1'b1) stalls_seen++;
    if (bus.mc_ready === 1'b0) full_seen++;
  end

  initial begin
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.mc_issue = 1'b0; bus.mc_issue_addr = '0;
    bus.mc_valid = 1'b0; bus.mc_addr = '0; bus.mc_data = '0;

    rst = 1'b1; idle(2); rst = 1'b0;
    // WB only
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    idle(1);
    // Contention: r7 buffered behind WB r3
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 1'b1, 5'd7, 32'h11);
    cyc(1'b1, 5'd3, 32'h23, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    idle(2);
    // Reset mid-traffic with entries queued
    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 1'b1, 5'd2, 32'h2);
    cyc(1'b1, 5'd1, 32'h3, 1'b1, 5'd6, 1'b1, 5'd6, 32'h6);
    rst = 1'b1; idle(2); rst = 1'b0;
    idle(2);
    // Full FIFO and starvation with WB held
    for (int i = 0; i < 12; i++)
      cyc(1'b1, 5'd8, 32'h100 + i, 1'b0, 5'd0, i < 3, 5'(10 + i), 32'hA0 + i);
    idle(4);
    // r0 guard on both paths
    cyc(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hBAD1);
    idle(3);
    // Error pulses and same-cycle set/clear of r4
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd1, 32'h98, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    idle(3);
    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      rst = (i == 700) || (i == 701);
      cyc(($urandom % 10) < 7, pick[$urandom_range(0, 5)], $urandom,
          ($urandom % 4) == 0, pick[$urandom_range(0, 5)],
          ($urandom % 3) == 0, pick[$urandom_range(0, 5)], $urandom);
    end
    rst = 1'b0;
    idle(8);
    @(negedge clk);
    #1;
    checks++;
    if (exp_wr.size() == 0 && exp_st.size() == 0) passed++;
    else $display("FAIL drain: %0d writes and %0d status entries left, want 0", exp_wr.size(), exp_st.size());
    checks++;
    if (stalls_seen > 0) passed++;
    else $display("FAIL stall_seen: got %0d wb_stall pulses, want >0", stalls_seen);
    checks++;
    if (full_seen > 0) passed++;
    else $display("FAIL full_seen: got %0d cycles with mc_ready=0, want >0", full_seen);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
